delay_sched: RTL

Round-robin scheduler that shares one programmable delay counter among NREQ requesters. Each requester asks for a delay of `len` cycles. The block grants the counter to one requester at a time, counts the delay, and signals completion with a one-cycle `done` pulse. It sits in front of the periodic-delay datapath so that several timing clients can reuse a single counter.

---
 rtl/delay_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/delay_sched.sv
// delay_sched: round-robin arbiter in front of one shared programmable delay
// counter. The winner of arbitration owns the counter for len+1 counting
// cycles plus a one-cycle DONE, and an IDLE cycle always separates two jobs.
module delay_sched #(
  parameter int NREQ   = 4,
  parameter int CBITS  = 15,
  parameter int MAXLEN = 22500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  err,
  output logic [CBITS-1:0]      cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] MAX_C = CBITS'(MAXLEN);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [PW-1:0]    own, own_n;
  logic [CBITS-1:0] cnt_q, cnt_n;
  logic             err_q, err_n;

  logic [CBITS-1:0] len_a [NREQ];
  logic             found;
  logic [PW-1:0]    win;

  // Index base+off wrapped into 0..NREQ-1 (works for non-power-of-two NREQ).
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Split the packed length bus into one field per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_a[i] = len[i*CBITS +: CBITS];
  end

  // Round-robin search: first active request at or after ptr.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[wrap_idx(ptr, i)]) begin
        found = 1'b1;
        win   = wrap_idx(ptr, i);
      end
    end
  end

  // Next-state logic: arbitration in IDLE, count/abort in COUNT, release in DONE.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_n = state;
    ptr_n   = ptr;
    own_n   = own;
    cnt_n   = cnt_q;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (found) begin
          state_n = COUNT;
          own_n   = win;
          ptr_n   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          // len is captured here only; the counter ignores later changes.
          if (len_a[win] > MAX_C) begin
            cnt_n = MAX_C;
            err_n = 1'b1;
          end else begin
            cnt_n = len_a[win];
          end
        end
      end
      COUNT: begin
        if (!req[own]) begin
          // Abort: release the counter without a done pulse.
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      own   <= own_n;
      cnt_q <= cnt_n;
      err_q <= err_n;
    end
  end

  // Outputs decoded from registered state only, never directly from req.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (state != IDLE) gnt[own]  = 1'b1;
    if (state == DONE) done[own] = 1'b1;
  end

  assign busy = (state != IDLE);
  assign err  = err_q;
  assign cnt  = cnt_q;

endmodule
